memctrl: RTL and testbench

Memory controller between the pipeline and the byte-wide RAM/IO bus. It serves two requesters: the MEM stage (loads/stores of 1, 2 or 4 bytes) and the IF stage (32-bit instruction fetch). Each granted request is serialized into single-byte RAM cycles, little-endian, and completion is returned with a one-cycle done pulse. The data port has priority over the fetch port.

---
 rtl/memctrl_pkg.sv | 45 ++++
 rtl/memctrl_arbiter.sv | 49 ++++
 rtl/memctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_memctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memctrl_pkg.sv
// -----------------------------------------------------------------------------
// memctrl_pkg
// Shared definitions for the memory controller and its request arbiter:
//   - width codes carried on mem_width_in (byte / half / word)
//   - controller state encoding and request owner encoding
//   - IO region select (address bits [17:16] == 2'b11)
//   - zero word used to clear the load assembly register
//   - width_bytes(): width code -> byte count (unknown codes mean 4 bytes)
//   - in_io_region(): region test on address bits [17:16]
// No ports (package).
// -----------------------------------------------------------------------------
package memctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_READ  = 2'b01,
      ST_WRITE = 2'b10
   } state_t;

   typedef enum logic {
      OWN_MEM = 1'b0,
      OWN_IF  = 1'b1
   } owner_t;

   localparam logic [2:0]  WIDTH_BYTE    = 3'b001;
   localparam logic [2:0]  WIDTH_HALF    = 3'b010;
   localparam logic [2:0]  WIDTH_WORD    = 3'b100;
   localparam logic [1:0]  IO_REGION_SEL = 2'b11;
   localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

   // Any width code other than byte or half is served as a full word.
   function automatic logic [2:0] width_bytes(input logic [2:0] code);
      case (code)
         WIDTH_BYTE: return 3'd1;
         WIDTH_HALF: return 3'd2;
         WIDTH_WORD: return 3'd4;
         default:    return 3'd4;
      endcase
   endfunction

   function automatic logic in_io_region(input logic [1:0] sel);
      return sel == IO_REGION_SEL;
   endfunction

endpackage

// File: rtl/memctrl_arbiter.sv
// -----------------------------------------------------------------------------
// memctrl_arbiter
// Combinational grant between the MEM-stage data port and the IF-stage fetch
// port. The data port always wins when both request in the same cycle. The
// selected request is encoded as owner, direction, byte count and address so
// the controller can latch it in a single step.
// Ports:
//   mem_enable, mem_read_or_write, mem_width, mem_address : MEM request
//   inst_enable, inst_address                             : IF request
//   grant   : some request is present
//   owner   : which port the request belongs to
//   write   : request is a store (fetches are always reads)
//   nbytes  : number of byte cycles (1, 2 or 4)
//   address : base byte address of the request
// -----------------------------------------------------------------------------
module memctrl_arbiter
   import memctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              mem_enable,
   input  logic              mem_read_or_write,
   input  logic [2:0]        mem_width,
   input  logic [ADDR_W-1:0] mem_address,
   input  logic              inst_enable,
   input  logic [ADDR_W-1:0] inst_address,
   output logic              grant,
   output owner_t            owner,
   output logic              write,
   output logic [2:0]        nbytes,
   output logic [ADDR_W-1:0] address
);

   always_comb begin
      grant = mem_enable | inst_enable;
      if (mem_enable) begin
         owner   = OWN_MEM;
         write   = mem_read_or_write;
         nbytes  = width_bytes(mem_width);
         address = mem_address;
      end else begin
         owner   = OWN_IF;
         write   = 1'b0;
         nbytes  = 3'd4;
         address = inst_address;
      end
   end

endmodule

// File: rtl/memctrl.sv
// -----------------------------------------------------------------------------
// memctrl
// Memory controller between the pipeline and a byte-wide synchronous RAM/IO
// bus. Serves the MEM stage (1/2/4-byte loads and stores) and the IF stage
// (4-byte fetches); the MEM port has priority. Each granted request becomes a
// run of single-byte RAM cycles at base+k (little-endian, address wraps), and
// completion is signalled with a one-cycle done pulse on the owning port.
//
// Optional build macro MEMCTRL_IO_STALL_EN: adds io_buffer_full_in. While it
// is high, a write byte whose address lies in the IO region (bits [17:16] ==
// 2'b11) is held back; the byte index does not advance until the flag drops.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_enable_in            MEM request valid
//   mem_read_or_write_in     0 = load, 1 = store
//   mem_width_in             3'b001 byte, 3'b010 half, 3'b100 word
//   mem_address_in           MEM byte address
//   mem_data_in              store data, low bytes used
//   mem_busy_out             controller not idle
//   mem_done_out             one-cycle pulse, MEM request finished
//   mem_data_out             load data, zero-extended, held until next done
//   inst_enable_in           fetch request valid
//   inst_address_in          fetch address
//   inst_busy_out            controller not idle or MEM request pending
//   inst_done_out            one-cycle pulse, fetch finished
//   inst_out                 fetched word, held until next fetch done
//   io_buffer_full_in        (MEMCTRL_IO_STALL_EN only) IO write back-pressure
//   ram_din_in               RAM read byte, one cycle after its address
//   ram_dout_out             RAM write byte
//   ram_a_out                RAM byte address (0 when no byte cycle)
//   ram_wr_out               RAM write strobe
// -----------------------------------------------------------------------------
module memctrl
   import memctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_enable_in,
   input  logic              mem_read_or_write_in,
   input  logic [2:0]        mem_width_in,
   input  logic [ADDR_W-1:0] mem_address_in,
   input  logic [DATA_W-1:0] mem_data_in,
   output logic              mem_busy_out,
   output logic              mem_done_out,
   output logic [DATA_W-1:0] mem_data_out,
   input  logic              inst_enable_in,
   input  logic [ADDR_W-1:0] inst_address_in,
   output logic              inst_busy_out,
   output logic              inst_done_out,
   output logic [DATA_W-1:0] inst_out,
`ifdef MEMCTRL_IO_STALL_EN
   input  logic              io_buffer_full_in,
`endif
   input  logic [7:0]        ram_din_in,
   output logic [7:0]        ram_dout_out,
   output logic [ADDR_W-1:0] ram_a_out,
   output logic              ram_wr_out
);

   state_t            state;
   state_t            state_next;
   logic [2:0]        k;
   logic [2:0]        k_prev;
   logic [2:0]        n;
   owner_t            owner;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] byte_addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] asm_word;
   logic [DATA_W-1:0] asm_next;

   logic              grant;
   owner_t            req_owner;
   logic              req_write;
   logic [2:0]        req_nbytes;
   logic [ADDR_W-1:0] req_addr;

   logic              accept;
   logic              stall;
   logic              issue;
   logic              last_write;

   memctrl_arbiter #(
      .ADDR_W (ADDR_W)
   ) u_arbiter (
      .mem_enable        (mem_enable_in),
      .mem_read_or_write (mem_read_or_write_in),
      .mem_width         (mem_width_in),
      .mem_address       (mem_address_in),
      .inst_enable       (inst_enable_in),
      .inst_address      (inst_address_in),
      .grant             (grant),
      .owner             (req_owner),
      .write             (req_write),
      .nbytes            (req_nbytes),
      .address           (req_addr)
   );

   // A request is not taken in the cycle a done pulse is out: the requester
   // still holds its enable for the request that just finished.
   assign accept     = (state == ST_IDLE) && grant && !mem_done_out && !inst_done_out;
   assign byte_addr  = base + ADDR_W'(k);

`ifdef MEMCTRL_IO_STALL_EN
   assign stall      = (state == ST_WRITE) && io_buffer_full_in &&
                       in_io_region(byte_addr[17:16]);
`else
   assign stall      = 1'b0;
`endif

   assign issue      = (state == ST_WRITE) && !stall;
   assign last_write = issue && (k == n - 3'd1);
   assign k_prev     = k - 3'd1;

   // In READ, k runs one step past the last address: that extra cycle is
   // where the final byte arrives from the synchronous RAM.
   always_comb begin
      asm_next = asm_word;
      if (k != 3'd0) begin
         asm_next[{k_prev[1:0], 3'b000} +: 8] = ram_din_in;
      end
   end

   // --- state register ---
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // --- next-state logic ---
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_next = req_write ? ST_WRITE : ST_READ;
            end
         end
         ST_READ: begin
            if (k == n) begin
               state_next = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (last_write) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // --- bus and busy outputs ---
   always_comb begin
      ram_a_out     = '0;
      ram_wr_out    = 1'b0;
      ram_dout_out  = 8'h00;
      mem_busy_out  = (state != ST_IDLE);
      inst_busy_out = (state != ST_IDLE) || mem_enable_in;
      if ((state == ST_READ) && (k != n)) begin
         ram_a_out = byte_addr;
      end
      if (issue) begin
         ram_a_out    = byte_addr;
         ram_wr_out   = 1'b1;
         ram_dout_out = wdata[{k[1:0], 3'b000} +: 8];
      end
   end

   // --- request latch and load assembly ---
   always_ff @(posedge clk) begin
      if (accept) begin
         base     <= req_addr;
         n        <= req_nbytes;
         wdata    <= mem_data_in;
         owner    <= req_owner;
         asm_word <= DATA_W'(ZERO_WORD);
      end else if (state == ST_READ) begin
         asm_word <= asm_next;
      end
   end

   // --- byte sequencing and completion ---
   always_ff @(posedge clk) begin
      if (rst) begin
         k             <= 3'd0;
         mem_done_out  <= 1'b0;
         inst_done_out <= 1'b0;
         mem_data_out  <= '0;
         inst_out      <= '0;
      end else begin
         mem_done_out  <= 1'b0;
         inst_done_out <= 1'b0;
         case (state)
            ST_IDLE: begin
               k <= 3'd0;
            end
            ST_READ: begin
               if (k == n) begin
                  k <= 3'd0;
                  if (owner == OWN_IF) begin
                     inst_done_out <= 1'b1;
                     inst_out      <= asm_next;
                  end else begin
                     mem_done_out  <= 1'b1;
                     mem_data_out  <= asm_next;
                  end
               end else begin
                  k <= k + 3'd1;
               end
            end
            ST_WRITE: begin
               if (last_write) begin
                  k            <= 3'd0;
                  mem_done_out <= 1'b1;
               end else if (issue) begin
                  k <= k + 3'd1;
               end
            end
            default: begin
               k <= 3'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memctrl.sv
// -----------------------------------------------------------------------------
// tb_memctrl
// Bench for memctrl: a byte RAM model on the bus, a transaction-level model of
// the controller's externally visible timing, directed scenarios and a
// randomized two-requester phase. Outputs are compared at the falling edge;
// inputs change 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_memctrl;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mem_enable_in = 1'b0;
   logic          mem_rw = 1'b0;
   logic [2:0]    mem_width = 3'b100;
   logic [31:0]   mem_addr = 32'h0;
   logic [31:0]   mem_wdata = 32'h0;
   logic          inst_enable_in = 1'b0;
   logic [31:0]   inst_addr = 32'h0;
   logic [7:0]    ram_din = 8'h00;
   logic          io_full = 1'b0;

   logic          mem_busy_out, mem_done_out, inst_busy_out, inst_done_out, ram_wr_out;
   logic [31:0]   mem_data_out, inst_out, ram_a_out;
   logic [7:0]    ram_dout_out;

   always #5 clk = ~clk;

   memctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .mem_enable_in        (mem_enable_in),
      .mem_read_or_write_in (mem_rw),
      .mem_width_in         (mem_width),
      .mem_address_in       (mem_addr),
      .mem_data_in          (mem_wdata),
      .mem_busy_out         (mem_busy_out),
      .mem_done_out         (mem_done_out),
      .mem_data_out         (mem_data_out),
      .inst_enable_in       (inst_enable_in),
      .inst_address_in      (inst_addr),
      .inst_busy_out        (inst_busy_out),
      .inst_done_out        (inst_done_out),
      .inst_out             (inst_out),
`ifdef MEMCTRL_IO_STALL_EN
      .io_buffer_full_in    (io_full),
`endif
      .ram_din_in           (ram_din),
      .ram_dout_out         (ram_dout_out),
      .ram_a_out            (ram_a_out),
      .ram_wr_out           (ram_wr_out)
   );

   // RAM on the bus, plus the model's own copy of what memory should hold.
   logic [7:0] ram    [bit [31:0]];
   logic [7:0] shadow [bit [31:0]];

   function automatic logic [7:0] dflt(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
   endfunction
   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      return ram.exists(a) ? ram[a] : dflt(a);
   endfunction
   function automatic logic [7:0] sh_rd(input logic [31:0] a);
      return shadow.exists(a) ? shadow[a] : dflt(a);
   endfunction

   always @(posedge clk) begin
      ram_din <= ram_rd(ram_a_out);
      if (ram_wr_out) ram[ram_a_out] = ram_dout_out;
   end

   task automatic poke(input logic [31:0] a, input logic [7:0] b);
      ram[a]    = b;
      shadow[a] = b;
   endtask

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   bit checking = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   // Model: one outstanding transaction described by kind, base, size and the
   // cycle it was accepted; outputs follow from the documented timing.
   bit          m_act, m_wr, m_if, m_done_next;
   logic [31:0] m_base, m_wd;
   int          m_n, m_acyc, m_issued;
   logic [31:0] e_mem_data = 32'h0;
   logic [31:0] e_inst = 32'h0;
   bit          mem_done_seen, inst_done_seen;
   bit          rand_mode = 1'b0;

   int          d_mem_cyc, d_inst_cyc, acc_cyc, wr_cnt, mdone_cnt;
   logic [31:0] d_mem_data;
   bit          log_en = 1'b0;
   logic [31:0] alog [$];

   function automatic int nbytes(input logic [2:0] w);
      return (w == 3'b001) ? 1 : (w == 3'b010) ? 2 : 4;
   endfunction

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(3))
         0:       return 32'hFFFF_FFF0 + 32'($urandom_range(15));
         1:       return 32'h0003_0000 + 32'($urandom_range(63));
         default: return 32'h0000_0100 + 32'($urandom_range(255));
      endcase
   endfunction

   task automatic rand_mem();
      logic [2:0] codes [6];
      codes = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b111, 3'b011};
      mem_enable_in = 1'b1;
      mem_rw        = 1'($urandom_range(1));
      mem_width     = codes[$urandom_range(5)];
      mem_addr      = pick_addr();
      mem_wdata     = $urandom;
   endtask

   task automatic rand_inst();
      inst_enable_in = 1'b1;
      inst_addr      = pick_addr();
   endtask

   task automatic cycle();
      bit          done_this, e_av, e_wr, e_busy, was_act;
      logic [31:0] e_a, a, w;
      logic [7:0]  e_do;
      int          t;
      @(negedge clk);
      done_this = 1'b0; e_av = 1'b0; e_wr = 1'b0; e_a = 32'h0; e_do = 8'h00;
      if (m_act) begin
         t = cyc - m_acyc;
         if (!m_wr) begin
            if (t >= 1 && t <= m_n) begin
               e_av = 1'b1;
               e_a  = m_base + 32'(t - 1);
            end
            if (t == m_n + 2) begin
               done_this = 1'b1;
               w = 32'h0;
               for (int i = 0; i < m_n; i++) w[8*i +: 8] = sh_rd(m_base + 32'(i));
               if (m_if) e_inst = w; else e_mem_data = w;
            end
         end else if (m_done_next) begin
            done_this = 1'b1;
         end else begin
            a = m_base + 32'(m_issued);
            if (!(io_full && a[17:16] == 2'b11)) begin
               e_av = 1'b1; e_wr = 1'b1; e_a = a;
               e_do = m_wd[8*m_issued +: 8];
               shadow[a] = e_do;
               m_issued++;
               if (m_issued == m_n) m_done_next = 1'b1;
            end
         end
      end
      e_busy = m_act && !done_this;
      if (checking) begin
         chk("mem_busy",  32'(mem_busy_out),  32'(e_busy));
         chk("inst_busy", 32'(inst_busy_out), 32'(e_busy || mem_enable_in));
         chk("ram_a",     ram_a_out,          e_a);
         chk("ram_wr",    32'(ram_wr_out),    32'(e_wr));
         if (e_wr) chk("ram_dout", 32'(ram_dout_out), 32'(e_do));
         chk("mem_done",  32'(mem_done_out),  32'(done_this && !m_if));
         chk("inst_done", 32'(inst_done_out), 32'(done_this && m_if));
         chk("mem_data",  mem_data_out,       e_mem_data);
         chk("inst_data", inst_out,           e_inst);
      end
      mem_done_seen  = done_this && !m_if;
      inst_done_seen = done_this && m_if;
      if (mem_done_out) begin d_mem_cyc = cyc; d_mem_data = mem_data_out; mdone_cnt++; end
      if (inst_done_out) d_inst_cyc = cyc;
      if (ram_wr_out) wr_cnt++;
      if (log_en && e_av && !e_wr) alog.push_back(ram_a_out);
      if (rst) begin
         m_act = 1'b0; m_done_next = 1'b0; e_mem_data = 32'h0; e_inst = 32'h0;
      end else begin
         was_act = m_act;
         if (done_this) begin m_act = 1'b0; m_done_next = 1'b0; end
         if (!was_act && (mem_enable_in || inst_enable_in)) begin
            m_act = 1'b1; m_acyc = cyc; m_issued = 0; m_done_next = 1'b0; acc_cyc = cyc;
            if (mem_enable_in) begin
               m_if = 1'b0; m_wr = mem_rw; m_n = nbytes(mem_width);
               m_base = mem_addr; m_wd = mem_wdata;
            end else begin
               m_if = 1'b1; m_wr = 1'b0; m_n = 4; m_base = inst_addr;
            end
         end
      end
      cyc++;
      @(posedge clk);
      #1;
      if (mem_done_seen) begin
         if (rand_mode && $urandom_range(1) == 1) rand_mem(); else mem_enable_in = 1'b0;
      end else if (rand_mode && !mem_enable_in && $urandom_range(3) == 0) begin
         rand_mem();
      end
      if (inst_done_seen) begin
         if (rand_mode && $urandom_range(1) == 1) rand_inst(); else inst_enable_in = 1'b0;
      end else if (rand_mode && !inst_enable_in && $urandom_range(3) == 0) begin
         rand_inst();
      end
   endtask

   task automatic wait_mem(input string nm);
      int i;
      i = 0;
      while (!mem_done_seen && i < 60) begin cycle(); i++; end
      if (!mem_done_seen) chk({nm, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic wait_inst(input string nm);
      int i;
      i = 0;
      while (!inst_done_seen && i < 60) begin cycle(); i++; end
      if (!inst_done_seen) chk({nm, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic wait_accept(input string nm);
      int i;
      i = 0;
      while (!m_act && i < 20) begin cycle(); i++; end
      if (!m_act) chk({nm, "_accept_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic start_mem(input logic rw, input logic [2:0] w, input logic [31:0] a,
                            input logic [31:0] d);
      mem_rw = rw; mem_width = w; mem_addr = a; mem_wdata = d; mem_enable_in = 1'b1;
      d_mem_cyc = -1;
   endtask

   initial begin
      int i;
      repeat (3) cycle();
      rst = 1'b0;
      checking = 1'b1;
      chk("rst_ram_a",    ram_a_out,            32'h0);
      chk("rst_ram_wr",   32'(ram_wr_out),      32'h0);
      chk("rst_mem_data", mem_data_out,         32'h0);
      chk("rst_busy",     32'(mem_busy_out),    32'h0);
      cycle();

      // Word load with known bytes.
      poke(32'h1000, 8'h11); poke(32'h1001, 8'h22);
      poke(32'h1002, 8'h33); poke(32'h1003, 8'h44);
      wr_cnt = 0;
      start_mem(1'b0, 3'b100, 32'h1000, 32'h0);
      wait_mem("lw");
      chk("lw_latency", 32'(d_mem_cyc - acc_cyc), 32'd6);
      chk("lw_data",    d_mem_data,               32'h4433_2211);
      chk("lw_no_write", 32'(wr_cnt),             32'd0);
      cycle();

      // Halfword store.
      wr_cnt = 0;
      start_mem(1'b1, 3'b010, 32'h2002, 32'hDEAD_BEEF);
      wait_mem("sh");
      chk("sh_latency", 32'(d_mem_cyc - acc_cyc), 32'd3);
      chk("sh_byte0",   32'(ram_rd(32'h2002)),    32'h0000_00EF);
      chk("sh_byte1",   32'(ram_rd(32'h2003)),    32'h0000_00BE);
      chk("sh_untouched", 32'(ram.exists(32'h2004)), 32'd0);
      chk("sh_wr_count", 32'(wr_cnt),             32'd2);
      cycle();

      // Simultaneous requests: byte load first, then the fetch.
      poke(32'h10, 8'hA5);
      inst_addr = 32'h0; inst_enable_in = 1'b1; d_inst_cyc = -1;
      start_mem(1'b0, 3'b001, 32'h10, 32'h0);
      wait_inst("pri");
      chk("pri_lb_data", d_mem_data,                 32'h0000_00A5);
      chk("pri_gap",     32'(d_inst_cyc - d_mem_cyc), 32'd7);
      cycle();

      // Fetch wrapping the top of the address space.
      alog.delete();
      log_en = 1'b1;
      inst_addr = 32'hFFFF_FFFE; inst_enable_in = 1'b1;
      wait_inst("wrap");
      log_en = 1'b0;
      chk("wrap_count", 32'(alog.size()), 32'd4);
      if (alog.size() == 4) begin
         chk("wrap_a0", alog[0], 32'hFFFF_FFFE);
         chk("wrap_a1", alog[1], 32'hFFFF_FFFF);
         chk("wrap_a2", alog[2], 32'h0000_0000);
         chk("wrap_a3", alog[3], 32'h0000_0001);
      end
      cycle();

      // Reset in the middle of a word store.
      start_mem(1'b1, 3'b100, 32'h3000, 32'h1122_3344);
      wait_accept("rsw");
      cycle();
      rst = 1'b1; mem_enable_in = 1'b0; mdone_cnt = 0;
      cycle();
      rst = 1'b0;
      chk("rsw_wr",       32'(ram_wr_out),   32'd0);
      chk("rsw_a",        ram_a_out,         32'h0);
      chk("rsw_busy",     32'(mem_busy_out), 32'd0);
      chk("rsw_mem_data", mem_data_out,      32'h0);
      repeat (4) cycle();
      chk("rsw_no_done",  32'(mdone_cnt),                 32'd0);
      chk("rsw_byte0",    32'(ram_rd(32'h3000)),          32'h44);
      chk("rsw_byte1",    32'(ram_rd(32'h3001)),          32'h33);
      chk("rsw_byte2_no", 32'(ram.exists(32'h3002)),      32'd0);
      start_mem(1'b1, 3'b001, 32'h3002, 32'h0000_0077);
      wait_mem("after_rst");
      chk("after_rst_latency", 32'(d_mem_cyc - acc_cyc), 32'd2);
      chk("after_rst_byte",    32'(ram_rd(32'h3002)),    32'h77);
      cycle();

`ifdef MEMCTRL_IO_STALL_EN
      // IO store held back for three cycles.
      io_full = 1'b1;
      start_mem(1'b1, 3'b001, 32'h0003_0000, 32'h0000_0041);
      wait_accept("io");
      repeat (3) cycle();
      io_full = 1'b0;
      wait_mem("io");
      chk("io_latency", 32'(d_mem_cyc - acc_cyc), 32'd5);
      chk("io_byte",    32'(ram_rd(32'h0003_0000)), 32'h41);
      cycle();
`endif

      // Randomized traffic from both requesters.
      rand_mode = 1'b1;
      repeat (3000) cycle();
      rand_mode = 1'b0;
      i = 0;
      while ((mem_enable_in || inst_enable_in) && i < 200) begin cycle(); i++; end
      if (mem_enable_in || inst_enable_in) chk("drain_timeout", 32'd1, 32'd0);
      repeat (5) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
